level_column_streamer: RTL
==========================

# level_column_streamer

Feeds the block-column array that holds the visible level. After reset it streams the first ten 30-bit level columns in with `Shift` pulses. During play it prefetches the next column from level ROM and issues one scroll `Shift` per frame while Mario is at or past the scroll threshold. It also tells the Mario controller to move left by one block width, and it stops at the end of the level.

## Interface
- `LEVEL_COLS`, default 200: total columns in the level ROM; legal range 10..255.
- `SCROLL_X`, default 10'd320: Mario screen X at or above which a scroll is requested.
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high; clock `Clk`.
- `frame_clk`  in  1  vertical-sync level; its rising edge is one frame tick.
- `Mario_X_Pos`  in  10  Mario centre X, screen pixels.
- `rom_addr`  out  8  level ROM column address; equals the internal `next_col` counter.
- `rom_data`  in  30  ROM column for the `rom_addr` of the previous cycle; 10 rows × 3-bit block ID, row 0 in [2:0].
- `new_block_id`  out  30  column to load; valid whenever `Shift`=1.
- `Shift`  out  1  one-cycle pulse: array shifts left and loads `new_block_id` at the right.
- `mario_shift_left`  out  1  one-cycle pulse, coincident with a scroll `Shift` only: Mario X −= 40.
- `init_done`  out  1  high once the preload of ten columns is complete.
- `level_end`  out  1  high once all `LEVEL_COLS` columns have been fetched; no more scrolling.
- `cols_loaded`  out  8  count of `Shift` pulses issued since reset.

## Operation
- State machine states: `FETCH`, `CAPTURE`, `SHIFT`, `IDLE`, `END`.
  - `FETCH`: 1 cycle; the ROM sees `rom_addr`=`next_col`. Goes to `CAPTURE`.
  - `CAPTURE`: latch `rom_data` into `buf`; `next_col`++; set `buf_valid`.
    - If preloading (`cols_loaded` < 10), go to `SHIFT`.
    - Otherwise, go to `IDLE`.
  - `SHIFT`: `Shift`=1 and `new_block_id`=`buf`; `cols_loaded`++; clear `buf_valid`.
    - During preload, `mario_shift_left`=0. Otherwise `mario_shift_left`=1 and `scroll_pend` clears.
    - Next state: `FETCH` if `next_col` < `LEVEL_COLS`, else `END`.
    - When the 10th preload `Shift` has been issued, `init_done` sets on the next cycle.
  - `IDLE`: wait with `buf_valid`=1.
    - If `scroll_pend`=1, go to `SHIFT`.
    - Once the `IDLE` buffer holds the last column (`next_col`==`LEVEL_COLS`), `level_end`=1.
  - `END`: terminal; `level_end`=1; no outputs pulse; ignores ticks. Only `Reset` leaves it.
- Frame tick detection: a registered copy of `frame_clk`; tick = `frame_clk` & ~prev.
- Scroll request: on a tick with `init_done`=1 and `Mario_X_Pos` >= `SCROLL_X`, set `scroll_pend`.
  - The request is held in any state until serviced.
  - A tick while `scroll_pend` is already set is absorbed: at most one scroll per pending request.
- `new_block_id` holds `buf` at all times. It is 0 after reset until the first `CAPTURE`.
- Width rules:
  - `next_col` and `cols_loaded` are 8-bit unsigned.
  - `next_col` saturates at `LEVEL_COLS` and never wraps.
  - `cols_loaded` saturates at 255.

## Timing
- Reset values:
  - State = `FETCH`; `next_col`=0; `rom_addr`=0; `cols_loaded`=0.
  - `buf`=0; `new_block_id`=0; `buf_valid`=0; `scroll_pend`=0; prev `frame_clk`=0.
  - `Shift`=0, `mario_shift_left`=0, `init_done`=0, `level_end`=0.
- Reset asserted mid-operation in any state returns to the reset values on the next edge. An in-flight `Shift` is not completed.
- Preload takes 3 cycles per column: the first `Shift` is in cycle 3 after `Reset` deasserts, and `Shift` repeats every 3 cycles.
  - 10th `Shift` is in cycle 30; `init_done`=1 from cycle 31.
  - Column 10 is prefetched in cycles 31–32; `IDLE` is reached in cycle 33.
- Scroll latency: tick in cycle T while in `IDLE` → `scroll_pend` in T+1 → `Shift`/`mario_shift_left` in T+2 → prefetch done by T+4.
- A tick that arrives during `FETCH` or `CAPTURE` is serviced on the first `IDLE` cycle after `CAPTURE` completes.
- The tick and the scroll decision use `Mario_X_Pos` sampled in the tick cycle.

## Test plan
- Reset then run:
  - Exactly 10 `Shift` pulses in cycles 3, 6, …, 30, with `new_block_id` equal to ROM columns 0..9.
  - `mario_shift_left`=0 throughout; `init_done`=1 at cycle 31; `rom_addr`=11 after the prefetch.
- `Mario_X_Pos`=330 with a tick: one `Shift` carrying ROM column 10, coincident with `mario_shift_left`=1; `cols_loaded`=11.
- `Mario_X_Pos`=319 with ticks: no `Shift`. At `Mario_X_Pos`=320, one `Shift` per tick only.
- Two ticks on consecutive cycles while `Mario_X_Pos`=400: exactly one scroll `Shift`.
- With `LEVEL_COLS`=12:
  - After scrolls, `new_block_id` carries ROM columns 10 and 11; `level_end`=1 once column 11 is fetched (in `IDLE`).
  - After its `Shift`, the state is `END`; further ticks give no `Shift`.
  - `level_end` and `init_done` stay at 1.
- `Reset` asserted during the scroll `SHIFT` cycle: next cycle all outputs are at reset values, and the preload restarts from column 0.

Source files
------------

// File: rtl/level_column_streamer_if.sv
// Bus between the level column streamer, the level ROM, the block-column
// array and the Mario controller. The streamer side is the master.
interface level_column_streamer_if;
   logic        frame_clk;
   logic [9:0]  Mario_X_Pos;
   logic [7:0]  rom_addr;
   logic [29:0] rom_data;
   logic [29:0] new_block_id;
   logic        Shift;
   logic        mario_shift_left;
   logic        init_done;
   logic        level_end;
   logic [7:0]  cols_loaded;

   modport master (
      input  frame_clk,
      input  Mario_X_Pos,
      input  rom_data,
      output rom_addr,
      output new_block_id,
      output Shift,
      output mario_shift_left,
      output init_done,
      output level_end,
      output cols_loaded
   );

   modport slave (
      output frame_clk,
      output Mario_X_Pos,
      output rom_data,
      input  rom_addr,
      input  new_block_id,
      input  Shift,
      input  mario_shift_left,
      input  init_done,
      input  level_end,
      input  cols_loaded
   );
endinterface

// File: rtl/level_column_streamer.sv
// Streams level columns from ROM into the visible block-column array:
// preloads the first ten columns after reset, then prefetches one column
// ahead and shifts it in once per frame while Mario sits past the scroll line.
module level_column_streamer #(
   parameter int unsigned LEVEL_COLS = 200,
   parameter logic [9:0]  SCROLL_X   = 10'd320
) (
   input  logic Clk,
   input  logic Reset,
   level_column_streamer_if.master bus
);

   typedef enum logic [2:0] {
      FETCH,
      CAPTURE,
      SHIFT,
      IDLE,
      END
   } state_t;

   localparam logic [7:0] LAST_COL    = 8'(LEVEL_COLS);
   localparam logic [7:0] PRELOAD_COL = 8'd10;

   state_t      state_q, state_d;
   logic [7:0]  next_col_q, next_col_d;
   logic [7:0]  cols_loaded_q, cols_loaded_d;
   logic [29:0] blk_buf_q, blk_buf_d;
   logic        buf_valid_q, buf_valid_d;
   logic        scroll_pend_q, scroll_pend_d;
   logic        frame_prev_q, frame_prev_d;
   logic        shift_q, shift_d;
   logic        mario_shift_left_q, mario_shift_left_d;
   logic        init_done_q, init_done_d;
   logic        level_end_q, level_end_d;

   logic        tick;
   logic        scroll_set;
   logic        scroll_clear;

   // Next-state logic: sequencer, frame tick edge detect, scroll request and registered outputs
   always_comb begin
      state_d            = state_q;
      next_col_d         = next_col_q;
      cols_loaded_d      = cols_loaded_q;
      blk_buf_d          = blk_buf_q;
      buf_valid_d        = buf_valid_q;
      frame_prev_d       = bus.frame_clk;

      tick         = bus.frame_clk & ~frame_prev_q;
      scroll_set   = tick & init_done_q & (bus.Mario_X_Pos >= SCROLL_X) & (state_q != END);
      scroll_clear = (state_q == SHIFT) & mario_shift_left_q;

      if (scroll_clear) begin
         scroll_pend_d = 1'b0;
      end else begin
         scroll_pend_d = scroll_pend_q | scroll_set;
      end

      case (state_q)
         FETCH: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            blk_buf_d   = bus.rom_data;
            buf_valid_d = 1'b1;
            if (next_col_q < LAST_COL) begin
               next_col_d = next_col_q + 8'd1;
            end
            if (cols_loaded_q < PRELOAD_COL) begin
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            buf_valid_d = 1'b0;
            if (cols_loaded_q != 8'hFF) begin
               cols_loaded_d = cols_loaded_q + 8'd1;
            end
            if (next_col_q < LAST_COL) begin
               state_d = FETCH;
            end else begin
               state_d = END;
            end
         end
         IDLE: begin
            if (scroll_pend_q && buf_valid_q) begin
               state_d = SHIFT;
            end
         end
         END: begin
            state_d = END;
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      shift_d            = (state_d == SHIFT);
      mario_shift_left_d = (state_q == IDLE) && (state_d == SHIFT);
      init_done_d        = init_done_q | (cols_loaded_d >= PRELOAD_COL);
      level_end_d        = level_end_q | (state_d == END) |
                           ((state_d == IDLE) && (next_col_d == LAST_COL));
   end

   // State and output registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q            <= FETCH;
         next_col_q         <= 8'd0;
         cols_loaded_q      <= 8'd0;
         blk_buf_q          <= 30'd0;
         buf_valid_q        <= 1'b0;
         scroll_pend_q      <= 1'b0;
         frame_prev_q       <= 1'b0;
         shift_q            <= 1'b0;
         mario_shift_left_q <= 1'b0;
         init_done_q        <= 1'b0;
         level_end_q        <= 1'b0;
      end else begin
         state_q            <= state_d;
         next_col_q         <= next_col_d;
         cols_loaded_q      <= cols_loaded_d;
         blk_buf_q          <= blk_buf_d;
         buf_valid_q        <= buf_valid_d;
         scroll_pend_q      <= scroll_pend_d;
         frame_prev_q       <= frame_prev_d;
         shift_q            <= shift_d;
         mario_shift_left_q <= mario_shift_left_d;
         init_done_q        <= init_done_d;
         level_end_q        <= level_end_d;
      end
   end

   assign bus.rom_addr         = next_col_q;
   assign bus.new_block_id     = blk_buf_q;
   assign bus.Shift            = shift_q;
   assign bus.mario_shift_left = mario_shift_left_q;
   assign bus.init_done        = init_done_q;
   assign bus.level_end        = level_end_q;
   assign bus.cols_loaded      = cols_loaded_q;

endmodule
